// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/JUMP/PERF with a memory ready handshake.
// Optional feature macro: CTRL_PERF_EN builds the perf opcode, the PERF state and its latency counter.
module mips_multicycle_ctrl #(
    parameter int PERF_LAT = 4,
    parameter int OPW      = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_mem_ready,
    output logic           o_mem_req,
    output logic           o_mem_read,
    output logic           o_mem_write,
    output logic           o_ir_write,
    output logic           o_pc_write,
    output logic [1:0]     o_reg_dst,
    output logic [1:0]     o_mem_to_reg,
    output logic [1:0]     o_alu_op,
    output logic           o_jump,
    output logic           o_branch,
    output logic           o_alu_src,
    output logic           o_reg_write,
    output logic           o_sign_or_zero,
    output logic           o_illegal,
    output logic           o_retire,
    output logic [2:0]     o_state
);

    localparam logic [OPW-1:0] OP_R    = 'h00;
    localparam logic [OPW-1:0] OP_J    = 'h02;
    localparam logic [OPW-1:0] OP_JAL  = 'h03;
    localparam logic [OPW-1:0] OP_BEQ  = 'h04;
    localparam logic [OPW-1:0] OP_ADDI = 'h08;
    localparam logic [OPW-1:0] OP_SLTI = 'h0A;
    localparam logic [OPW-1:0] OP_LW   = 'h23;
    localparam logic [OPW-1:0] OP_SW   = 'h2B;
`ifdef CTRL_PERF_EN
    localparam logic [OPW-1:0] OP_PERF = 'h33;
    localparam int CW = $clog2(PERF_LAT + 1);
`endif

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_JUMP   = 3'd5,
        S_PERF   = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [OPW-1:0] r_op;
`ifdef CTRL_PERF_EN
    logic [CW-1:0]  r_cnt;
`endif

    logic       w_mem_req, w_mem_read, w_mem_write, w_ir_write, w_pc_write;
    logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_op;
    logic       w_jump, w_branch, w_alu_src, w_reg_write, w_sign_or_zero;
    logic       w_illegal, w_retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op <= i_opcode;
        end
    end

`ifdef CTRL_PERF_EN
    // Counter is loaded while leaving DECODE so PERF lasts exactly PERF_LAT cycles.
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (r_state == S_DECODE && w_next == S_PERF)
            r_cnt <= CW'(PERF_LAT - 1);
        else if (r_state == S_PERF && r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
    end
`endif

    always_comb begin
        w_next         = r_state;
        w_mem_req      = 1'b0;
        w_mem_read     = 1'b0;
        w_mem_write    = 1'b0;
        w_ir_write     = 1'b0;
        w_pc_write     = 1'b0;
        w_reg_dst      = 2'b00;
        w_mem_to_reg   = 2'b00;
        w_alu_op       = 2'b00;
        w_jump         = 1'b0;
        w_branch       = 1'b0;
        w_alu_src      = 1'b0;
        w_reg_write    = 1'b0;
        w_sign_or_zero = 1'b1;
        w_illegal      = 1'b0;
        w_retire       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req  = 1'b1;
                w_mem_read = 1'b1;
                if (i_mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                case (i_opcode)
                    OP_R, OP_SLTI, OP_ADDI, OP_LW, OP_SW, OP_BEQ: w_next = S_EXEC;
                    OP_J, OP_JAL:                                 w_next = S_JUMP;
`ifdef CTRL_PERF_EN
                    OP_PERF:                                      w_next = S_PERF;
`endif
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                case (r_op)
                    OP_R: w_next = S_WB;
                    OP_SLTI: begin
                        w_alu_op       = 2'b10;
                        w_alu_src      = 1'b1;
                        w_sign_or_zero = 1'b0;
                        w_next         = S_WB;
                    end
                    OP_ADDI: begin
                        w_alu_op  = 2'b11;
                        w_alu_src = 1'b1;
                        w_next    = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        w_alu_op  = 2'b11;
                        w_alu_src = 1'b1;
                        w_next    = S_MEM;
                    end
                    OP_BEQ: begin
                        w_branch = 1'b1;
                        w_alu_op = 2'b01;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_mem_read  = (r_op == OP_LW);
                w_mem_write = (r_op == OP_SW);
                if (i_mem_ready) begin
                    if (r_op == OP_LW) begin
                        w_next = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = (r_op == OP_R)  ? 2'b01 : 2'b00;
                w_mem_to_reg = (r_op == OP_LW) ? 2'b01 : 2'b00;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_JUMP: begin
                w_jump     = 1'b1;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
                if (r_op == OP_JAL) begin
                    w_reg_write  = 1'b1;
                    w_reg_dst    = 2'b10;
                    w_mem_to_reg = 2'b10;
                end
                w_next = S_FETCH;
            end
`ifdef CTRL_PERF_EN
            S_PERF: begin
                w_alu_op  = 2'b11;
                w_alu_src = 1'b1;
                if (r_cnt == '0)
                    w_next = S_WB;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    // Reset overrides every output combinationally so an aborted instruction never retires.
    assign o_mem_req      = !reset && w_mem_req;
    assign o_mem_read     = !reset && w_mem_read;
    assign o_mem_write    = !reset && w_mem_write;
    assign o_ir_write     = !reset && w_ir_write;
    assign o_pc_write     = !reset && w_pc_write;
    assign o_reg_dst      = reset ? 2'b00 : w_reg_dst;
    assign o_mem_to_reg   = reset ? 2'b00 : w_mem_to_reg;
    assign o_alu_op       = reset ? 2'b00 : w_alu_op;
    assign o_jump         = !reset && w_jump;
    assign o_branch       = !reset && w_branch;
    assign o_alu_src      = !reset && w_alu_src;
    assign o_reg_write    = !reset && w_reg_write;
    assign o_sign_or_zero = reset || w_sign_or_zero;
    assign o_illegal      = !reset && w_illegal;
    assign o_retire       = !reset && w_retire;
    assign o_state        = reset ? 3'd0 : r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-instruction expected cycle traces built from opcode class tables.
module tb_mips_multicycle_ctrl;

    localparam int PL = 7;

    typedef struct packed {
        logic [2:0] st;
        logic       req, rd, wr, irw, pcw;
        logic [1:0] rdst, mtr, aop;
        logic       jmp, br, src, rw, soz, ill, ret;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_read, mem_write, ir_write, pc_write;
    logic [1:0] reg_dst, mem_to_reg, alu_op;
    logic       jump, branch, alu_src, reg_write, sign_or_zero, illegal, retire;
    logic [2:0] state;
    outs_t      obs;

    int n_cmp = 0;
    int n_fail = 0;
    outs_t exp_q[$];
    logic  rdy_q[$];

    mips_multicycle_ctrl #(.PERF_LAT(PL), .OPW(6)) dut (
        .clk(clk), .reset(reset), .i_opcode(opcode), .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_mem_read(mem_read), .o_mem_write(mem_write),
        .o_ir_write(ir_write), .o_pc_write(pc_write), .o_reg_dst(reg_dst),
        .o_mem_to_reg(mem_to_reg), .o_alu_op(alu_op), .o_jump(jump), .o_branch(branch),
        .o_alu_src(alu_src), .o_reg_write(reg_write), .o_sign_or_zero(sign_or_zero),
        .o_illegal(illegal), .o_retire(retire), .o_state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, mem_req, mem_read, mem_write, ir_write, pc_write, reg_dst, mem_to_reg,
                  alu_op, jump, branch, alu_src, reg_write, sign_or_zero, illegal, retire};

    function automatic outs_t base(input logic [2:0] st);
        outs_t e = '0;
        e.st  = st;
        e.soz = 1'b1;
        return e;
    endfunction

    task automatic check(input string tag, input int cyc, input outs_t e);
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s cyc%0d: observed %h expected %h", tag, cyc, obs, e);
        end
    endtask

    task automatic push(input outs_t e, input logic r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    // Expected trace: fetch waits, fetch-ready, decode, then the opcode class's phase list.
    task automatic run_instr(input string tag, input logic [5:0] op, input int fw, input int mw,
                             input int stop_at);
        outs_t e;
        logic [5:0] junk;
        exp_q.delete();
        rdy_q.delete();
        e = base(3'd0); e.req = 1; e.rd = 1;
        for (int i = 0; i < fw; i++) push(e, 1'b0);
        e.irw = 1; e.pcw = 1; push(e, 1'b1);
        e = base(3'd1);
        case (op)
            6'h00, 6'h08, 6'h0A: begin
                push(e, 1'($urandom));
                e = base(3'd2);
                if (op == 6'h08) begin e.aop = 2'b11; e.src = 1; end
                if (op == 6'h0A) begin e.aop = 2'b10; e.src = 1; e.soz = 0; end
                push(e, 1'($urandom));
                e = base(3'd4); e.rw = 1; e.ret = 1;
                if (op == 6'h00) e.rdst = 2'b01;
                push(e, 1'($urandom));
            end
            6'h23, 6'h2B: begin
                push(e, 1'($urandom));
                e = base(3'd2); e.aop = 2'b11; e.src = 1; push(e, 1'($urandom));
                e = base(3'd3); e.req = 1;
                if (op == 6'h23) e.rd = 1; else e.wr = 1;
                for (int i = 0; i < mw; i++) push(e, 1'b0);
                if (op == 6'h2B) e.ret = 1;
                push(e, 1'b1);
                if (op == 6'h23) begin
                    e = base(3'd4); e.rw = 1; e.ret = 1; e.mtr = 2'b01; push(e, 1'($urandom));
                end
            end
            6'h04: begin
                push(e, 1'($urandom));
                e = base(3'd2); e.br = 1; e.aop = 2'b01; e.ret = 1; push(e, 1'($urandom));
            end
            6'h02, 6'h03: begin
                push(e, 1'($urandom));
                e = base(3'd5); e.jmp = 1; e.pcw = 1; e.ret = 1;
                if (op == 6'h03) begin e.rw = 1; e.rdst = 2'b10; e.mtr = 2'b10; end
                push(e, 1'($urandom));
            end
`ifdef CTRL_PERF_EN
            6'h33: begin
                push(e, 1'($urandom));
                e = base(3'd6); e.aop = 2'b11; e.src = 1;
                for (int i = 0; i < PL; i++) push(e, 1'($urandom));
                e = base(3'd4); e.rw = 1; e.ret = 1; push(e, 1'($urandom));
            end
`endif
            default: begin
                e.ill = 1; push(e, 1'($urandom));
            end
        endcase
        for (int i = 0; i < exp_q.size(); i++) begin
            if (stop_at >= 0 && i >= stop_at) break;
            @(negedge clk);
            junk = 6'($urandom);
            opcode = (i == fw + 1) ? op : junk;
            mem_ready = rdy_q[i];
            #1;
            check(tag, i, exp_q[i]);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'($urandom);
        #1 check(tag, 0, base(3'd0));
        @(negedge clk);
        mem_ready = 1'($urandom);
        #1 check(tag, 1, base(3'd0));
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [5:0] ops [10] = '{6'h00, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h33, 6'h3F};
        logic [5:0] rop;
        do_reset("reset_init");
        run_instr("addi", 6'h08, 0, 0, -1);
        run_instr("lw_waits", 6'h23, 3, 2, -1);
        run_instr("jal", 6'h03, 0, 0, -1);
        run_instr("j", 6'h02, 1, 0, -1);
        run_instr("beq", 6'h04, 0, 0, -1);
        run_instr("rtype", 6'h00, 2, 0, -1);
        run_instr("slti", 6'h0A, 0, 0, -1);
        run_instr("sw", 6'h2B, 0, 1, -1);
        run_instr("illegal", 6'h3F, 0, 0, -1);
        run_instr("perf", 6'h33, 0, 0, -1);
        run_instr("lw_abort", 6'h23, 0, 3, 4);
        do_reset("reset_mid");
        run_instr("post_reset", 6'h00, 0, 0, -1);
        for (int k = 0; k < 40; k++) begin
            rop = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 4) == 0) rop = 6'($urandom);
            run_instr("random", rop, $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
